// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes fetched words into a registered control
// entry with load-use interlock, flush, illegal detection and a bubble counter.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter bit EN_MEXT      = 1'b0,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_aluop,
  output logic [2:0]      out_cmpop,
  output logic [2:0]      out_regfilemux_sel,
  output logic            out_alumux1_sel,
  output logic [2:0]      out_alumux2_sel,
  output logic            out_cmpmux_sel,
  output logic            out_load_regfile,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic            out_muldiv,
  output logic [2:0]      out_muldiv_op,
  output logic            out_illegal,
  output logic            stall,
  output logic [15:0]     bubble_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      aluop;
    logic [2:0]      cmpop;
    logic [2:0]      regfilemux_sel;
    logic            alumux1_sel;
    logic [2:0]      alumux2_sel;
    logic            cmpmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            muldiv;
    logic [2:0]      muldiv_op;
    logic            illegal;
    logic            use_rs1;
    logic            use_rs2;
  } entry_t;

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  entry_t      w_dec;
  logic        w_bad;
  logic [31:0] w_imm32;

  // Decoder; an illegal word keeps only its raw fields and carries no side effects.
  always_comb begin
    w_dec   = '0;
    w_bad   = 1'b0;
    w_imm32 = '0;
    unique case (in_instr[6:0])
      OP_LUI: begin
        w_imm32 = w_imm_u;
        w_dec.load_regfile = 1'b1;
        w_dec.regfilemux_sel = 3'd2;
      end
      OP_AUIPC: begin
        w_imm32 = w_imm_u;
        w_dec.load_regfile = 1'b1;
        w_dec.alumux1_sel = 1'b1;
        w_dec.alumux2_sel = 3'd1;
      end
      OP_JAL: begin
        w_imm32 = w_imm_j;
        w_dec.load_regfile = 1'b1;
        w_dec.regfilemux_sel = 3'd4;
        w_dec.alumux1_sel = 1'b1;
        w_dec.alumux2_sel = 3'd5;
      end
      OP_JALR: begin
        w_imm32 = w_imm_i;
        w_dec.load_regfile = 1'b1;
        w_dec.regfilemux_sel = 3'd4;
        w_dec.use_rs1 = 1'b1;
      end
      OP_BR: begin
        w_imm32 = w_imm_b;
        w_dec.alumux1_sel = 1'b1;
        w_dec.alumux2_sel = 3'd2;
        w_dec.cmpop = w_f3;
        w_dec.use_rs1 = 1'b1;
        w_dec.use_rs2 = 1'b1;
        w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_LOAD: begin
        w_imm32 = w_imm_i;
        w_dec.load_regfile = 1'b1;
        w_dec.regfilemux_sel = 3'd3;
        w_dec.mem_read = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.mem_unsigned = w_f3[2];
        w_dec.use_rs1 = 1'b1;
        w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_imm32 = w_imm_s;
        w_dec.alumux2_sel = 3'd3;
        w_dec.mem_write = 1'b1;
        w_dec.mem_size = w_f3[1:0];
        w_dec.use_rs1 = 1'b1;
        w_dec.use_rs2 = 1'b1;
        w_bad = (w_f3 > 3'b010);
      end
      OP_IMM: begin
        w_imm32 = w_imm_i;
        w_dec.load_regfile = 1'b1;
        w_dec.use_rs1 = 1'b1;
        unique case (w_f3)
          3'b010: begin w_dec.cmpop = 3'b100; w_dec.regfilemux_sel = 3'd1; w_dec.cmpmux_sel = 1'b1; end
          3'b011: begin w_dec.cmpop = 3'b110; w_dec.regfilemux_sel = 3'd1; w_dec.cmpmux_sel = 1'b1; end
          3'b001: begin w_dec.aluop = 3'b001; w_bad = (w_f7 != F7_BASE); end
          3'b101: begin
            if (w_f7 == F7_BASE) w_dec.aluop = 3'b101;
            else if (w_f7 == F7_ALT) w_dec.aluop = 3'b010;
            else w_bad = 1'b1;
          end
          default: w_dec.aluop = w_f3;
        endcase
      end
      OP_REG: begin
        w_dec.load_regfile = 1'b1;
        w_dec.alumux2_sel = 3'd4;
        w_dec.use_rs1 = 1'b1;
        w_dec.use_rs2 = 1'b1;
        if (w_f7 == F7_MEXT) begin
          w_dec.muldiv = EN_MEXT;
          w_dec.muldiv_op = EN_MEXT ? w_f3 : 3'b000;
          w_bad = !EN_MEXT;
        end else if (w_f7 == F7_BASE) begin
          unique case (w_f3)
            3'b010:  begin w_dec.cmpop = 3'b100; w_dec.regfilemux_sel = 3'd1; end
            3'b011:  begin w_dec.cmpop = 3'b110; w_dec.regfilemux_sel = 3'd1; end
            default: w_dec.aluop = w_f3;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000) w_dec.aluop = 3'b011;
          else if (w_f3 == 3'b101) w_dec.aluop = 3'b010;
          else w_bad = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc     = in_pc;
    w_dec.imm    = XLEN'($signed(w_imm32));
    w_dec.opcode = in_instr[6:0];
    w_dec.rs1    = in_instr[19:15];
    w_dec.rs2    = in_instr[24:20];
    w_dec.rd     = w_dec.load_regfile ? in_instr[11:7] : 5'd0;
  end

  entry_t      r_ent;
  logic        r_held;
  logic [15:0] r_bubble;
  logic        w_stall, w_pop, w_accept, w_keep;

  assign w_stall = r_held && ex_load_valid && (ex_load_rd != 5'd0) &&
                   ((r_ent.use_rs1 && (r_ent.rs1 == ex_load_rd)) ||
                    (r_ent.use_rs2 && (r_ent.rs2 == ex_load_rd)));
  assign out_valid = !rst && r_held && !w_stall;
  assign stall     = !rst && w_stall;
  assign in_ready  = !rst && !flush && (!r_held || (out_valid && out_ready));
  assign w_pop     = out_valid && out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_keep    = !w_dec.illegal || ILLEGAL_TRAP;

  // Flush beats everything; a dropped illegal word still lets the old entry pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held   <= 1'b0;
      r_ent    <= '0;
      r_bubble <= '0;
    end else if (flush) begin
      r_held <= 1'b0;
    end else begin
      if (w_stall && (r_bubble != 16'hFFFF)) r_bubble <= r_bubble + 16'd1;
      if (w_accept && w_keep) begin
        r_held <= 1'b1;
        r_ent  <= w_dec;
      end else if (w_pop) begin
        r_held <= 1'b0;
      end
    end
  end

  assign out_pc             = r_ent.pc;
  assign out_imm            = r_ent.imm;
  assign out_rs1            = r_ent.rs1;
  assign out_rs2            = r_ent.rs2;
  assign out_rd             = r_ent.rd;
  assign out_opcode         = r_ent.opcode;
  assign out_aluop          = r_ent.aluop;
  assign out_cmpop          = r_ent.cmpop;
  assign out_regfilemux_sel = r_ent.regfilemux_sel;
  assign out_alumux1_sel    = r_ent.alumux1_sel;
  assign out_alumux2_sel    = r_ent.alumux2_sel;
  assign out_cmpmux_sel     = r_ent.cmpmux_sel;
  assign out_load_regfile   = r_ent.load_regfile;
  assign out_mem_read       = r_ent.mem_read;
  assign out_mem_write      = r_ent.mem_write;
  assign out_mem_size       = r_ent.mem_size;
  assign out_mem_unsigned   = r_ent.mem_unsigned;
  assign out_muldiv         = r_ent.muldiv;
  assign out_muldiv_op      = r_ent.muldiv_op;
  assign out_illegal        = r_ent.illegal;
  assign bubble_count       = r_bubble;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32M off / on) share stimulus and are
// checked every cycle against a mnemonic-level model plus literal spot checks.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  aluop;
    logic [2:0]  cmpop;
    logic [2:0]  rfmux;
    logic        am1;
    logic [2:0]  am2;
    logic        cmpmux;
    logic        lr;
    logic        mr;
    logic        mw;
    logic [1:0]  msize;
    logic        mun;
    logic        md;
    logic [2:0]  mdop;
    logic        ill;
  } dec_t;

  typedef struct packed {
    dec_t d;
    logic u1;
    logic u2;
  } ment_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        ex_load_valid = 1'b0;
  logic [4:0]  ex_load_rd = '0;
  logic        out_ready = 1'b1;

  wire         oInReady0, oInReady1, oValid0, oValid1, oStall0, oStall1;
  wire  [15:0] oBub0, oBub1;
  wire  dec_t  oDec0, oDec1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_MEXT(1'b0), .ILLEGAL_TRAP(1'b1)) dutNoM (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(oInReady0), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(oValid0), .out_ready(out_ready), .out_pc(oDec0.pc), .out_imm(oDec0.imm),
    .out_rs1(oDec0.rs1), .out_rs2(oDec0.rs2), .out_rd(oDec0.rd), .out_opcode(oDec0.opcode),
    .out_aluop(oDec0.aluop), .out_cmpop(oDec0.cmpop), .out_regfilemux_sel(oDec0.rfmux),
    .out_alumux1_sel(oDec0.am1), .out_alumux2_sel(oDec0.am2), .out_cmpmux_sel(oDec0.cmpmux),
    .out_load_regfile(oDec0.lr), .out_mem_read(oDec0.mr), .out_mem_write(oDec0.mw),
    .out_mem_size(oDec0.msize), .out_mem_unsigned(oDec0.mun), .out_muldiv(oDec0.md),
    .out_muldiv_op(oDec0.mdop), .out_illegal(oDec0.ill), .stall(oStall0), .bubble_count(oBub0)
  );

  decode_stage #(.XLEN(32), .EN_MEXT(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(oInReady1), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(oValid1), .out_ready(out_ready), .out_pc(oDec1.pc), .out_imm(oDec1.imm),
    .out_rs1(oDec1.rs1), .out_rs2(oDec1.rs2), .out_rd(oDec1.rd), .out_opcode(oDec1.opcode),
    .out_aluop(oDec1.aluop), .out_cmpop(oDec1.cmpop), .out_regfilemux_sel(oDec1.rfmux),
    .out_alumux1_sel(oDec1.am1), .out_alumux2_sel(oDec1.am2), .out_cmpmux_sel(oDec1.cmpmux),
    .out_load_regfile(oDec1.lr), .out_mem_read(oDec1.mr), .out_mem_write(oDec1.mw),
    .out_mem_size(oDec1.msize), .out_mem_unsigned(oDec1.mun), .out_muldiv(oDec1.md),
    .out_muldiv_op(oDec1.mdop), .out_illegal(oDec1.ill), .stall(oStall1), .bubble_count(oBub1)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] aluCode(input string op);
    case (op)
      "sll":   return 3'b001;
      "sra":   return 3'b010;
      "sub":   return 3'b011;
      "xor":   return 3'b100;
      "srl":   return 3'b101;
      "or":    return 3'b110;
      "and":   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Mnemonic-level reference decode; an illegal word keeps only pc/opcode/rs1/rs2/imm.
  function automatic ment_t modelDecode(input logic [31:0] w, input logic [31:0] pc, input bit enM);
    ment_t m;
    logic [2:0] f3;
    logic [6:0] f7;
    int iImm, sImm, bImm, jImm;
    bit bad, isImm;
    string op;
    m = '0;
    bad = 1'b0;
    isImm = 1'b0;
    op = "";
    f3 = w[14:12];
    f7 = w[31:25];
    iImm = int'($signed(w)) >>> 20;
    sImm = (int'($signed(w)) >>> 25) * 32 + int'(w[11:7]);
    bImm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    jImm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    case (w[6:0])
      7'h37: begin m.d.imm = w & 32'hFFFFF000; m.d.rfmux = 3'd2; m.d.lr = 1'b1; end
      7'h17: begin m.d.imm = w & 32'hFFFFF000; m.d.am1 = 1'b1; m.d.am2 = 3'd1; m.d.lr = 1'b1; end
      7'h6F: begin m.d.imm = 32'(jImm); m.d.rfmux = 3'd4; m.d.am1 = 1'b1; m.d.am2 = 3'd5; m.d.lr = 1'b1; end
      7'h67: begin m.d.imm = 32'(iImm); m.d.rfmux = 3'd4; m.d.lr = 1'b1; m.u1 = 1'b1; end
      7'h63: begin
        m.d.imm = 32'(bImm); m.d.am1 = 1'b1; m.d.am2 = 3'd2; m.d.cmpop = f3;
        m.u1 = 1'b1; m.u2 = 1'b1;
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h03: begin
        m.d.imm = 32'(iImm); m.d.rfmux = 3'd3; m.d.mr = 1'b1; m.d.lr = 1'b1;
        m.d.msize = f3[1:0]; m.d.mun = f3[2]; m.u1 = 1'b1;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'h23: begin
        m.d.imm = 32'(sImm); m.d.am2 = 3'd3; m.d.mw = 1'b1; m.d.msize = f3[1:0];
        m.u1 = 1'b1; m.u2 = 1'b1;
        bad = (f3 > 3'd2);
      end
      7'h13: begin
        m.d.imm = 32'(iImm); m.d.lr = 1'b1; m.u1 = 1'b1; isImm = 1'b1;
        case (f3)
          3'd0: op = "add";
          3'd1: begin op = "sll"; bad = (f7 != 7'h00); end
          3'd2: op = "slt";
          3'd3: op = "sltu";
          3'd4: op = "xor";
          3'd5: begin
            if (f7 == 7'h00) op = "srl";
            else if (f7 == 7'h20) op = "sra";
            else bad = 1'b1;
          end
          3'd6: op = "or";
          default: op = "and";
        endcase
      end
      7'h33: begin
        m.d.lr = 1'b1; m.d.am2 = 3'd4; m.u1 = 1'b1; m.u2 = 1'b1;
        if (f7 == 7'h01) begin
          if (enM) begin m.d.md = 1'b1; m.d.mdop = f3; end
          else bad = 1'b1;
        end else if (f7 == 7'h00) begin
          case (f3)
            3'd0: op = "add";
            3'd1: op = "sll";
            3'd2: op = "slt";
            3'd3: op = "sltu";
            3'd4: op = "xor";
            3'd5: op = "srl";
            3'd6: op = "or";
            default: op = "and";
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) op = "sub";
          else if (f3 == 3'd5) op = "sra";
          else bad = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (op == "slt" || op == "sltu") begin
      m.d.cmpop = (op == "slt") ? 3'b100 : 3'b110;
      m.d.rfmux = 3'd1;
      m.d.cmpmux = isImm;
    end else begin
      m.d.aluop = aluCode(op);
    end
    if (bad) begin
      logic [31:0] keepImm;
      keepImm = m.d.imm;
      m = '0;
      m.d.imm = keepImm;
      m.d.ill = 1'b1;
    end
    m.d.pc = pc;
    m.d.opcode = w[6:0];
    m.d.rs1 = w[19:15];
    m.d.rs2 = w[24:20];
    m.d.rd = m.d.lr ? w[11:7] : 5'd0;
    return m;
  endfunction

  bit    mHeld[2];
  ment_t mEnt[2];
  int    mBub[2];

  function automatic bit expStall(input int c);
    return !rst && mHeld[c] && ex_load_valid && (ex_load_rd != 5'd0) &&
           ((mEnt[c].u1 && (mEnt[c].d.rs1 == ex_load_rd)) || (mEnt[c].u2 && (mEnt[c].d.rs2 == ex_load_rd)));
  endfunction

  function automatic bit expValid(input int c);
    return !rst && mHeld[c] && !expStall(c);
  endfunction

  function automatic bit expReady(input int c);
    return !rst && !flush && (!mHeld[c] || (expValid(c) && out_ready));
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        mHeld[c] <= 1'b0;
        mEnt[c]  <= '0;
        mBub[c]  <= 0;
      end else if (flush) begin
        mHeld[c] <= 1'b0;
      end else begin
        if (expStall(c) && (mBub[c] < 65535)) mBub[c] <= mBub[c] + 1;
        if (in_valid && expReady(c)) begin
          mHeld[c] <= 1'b1;
          mEnt[c]  <= modelDecode(in_instr, in_pc, c == 1);
        end else if (expValid(c) && out_ready) begin
          mHeld[c] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      checkOutput($sformatf("valid%0d", c), 128'((c == 1) ? oValid1 : oValid0), 128'(expValid(c)));
      checkOutput($sformatf("inReady%0d", c), 128'((c == 1) ? oInReady1 : oInReady0), 128'(expReady(c)));
      checkOutput($sformatf("stall%0d", c), 128'((c == 1) ? oStall1 : oStall0), 128'(expStall(c)));
      checkOutput($sformatf("bubble%0d", c), 128'((c == 1) ? oBub1 : oBub0), 128'(mBub[c]));
      checkOutput($sformatf("decode%0d", c), 128'((c == 1) ? oDec1 : oDec0), 128'(mEnt[c].d));
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] SUB = 32'h402081B3;
  localparam logic [31:0] SW  = 32'h0020A423;
  localparam logic [31:0] MUL = 32'h022081B3;

  logic [31:0] vecs [16] = '{
    32'h00208463, 32'h123452B7, 32'hFFDFF0EF, 32'hFFF14203,
    32'h00013203, 32'h40335293, 32'hFFB42393, 32'h00B534B3,
    32'h800081B3, 32'hFFFFFFFF, 32'h00001517, 32'h00008067,
    32'h0020B423, 32'h0020A463, 32'h02009093, 32'h0020C1B3
  };

  initial begin
    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, '0, '0);
    checkOutput("rstInReady", 128'(oInReady1), 128'(0));
    checkOutput("rstValid", 128'(oValid1), 128'(0));
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("postRstReady", 128'(oInReady1), 128'(1));
    checkOutput("postRstBubble", 128'(oBub1), 128'(0));

    applyStimulus(1'b1, ADD, 32'h100);
    checkOutput("addValid", 128'(oValid1), 128'(1));
    checkOutput("addAluop", 128'(oDec1.aluop), 128'(0));
    checkOutput("addAm2", 128'(oDec1.am2), 128'(4));
    checkOutput("addRd", 128'(oDec1.rd), 128'(3));
    checkOutput("addRs1", 128'(oDec1.rs1), 128'(1));
    checkOutput("addRs2", 128'(oDec1.rs2), 128'(2));
    checkOutput("addLr", 128'(oDec1.lr), 128'(1));
    applyStimulus(1'b1, SUB, 32'h104);
    checkOutput("subValid", 128'(oValid1), 128'(1));
    checkOutput("subAluop", 128'(oDec1.aluop), 128'(3));
    applyStimulus(1'b1, SW, 32'h108);
    checkOutput("swMw", 128'(oDec1.mw), 128'(1));
    checkOutput("swSize", 128'(oDec1.msize), 128'(2));
    checkOutput("swLr", 128'(oDec1.lr), 128'(0));
    checkOutput("swRd", 128'(oDec1.rd), 128'(0));
    checkOutput("swImm", 128'(oDec1.imm), 128'(8));
    checkOutput("swAm2", 128'(oDec1.am2), 128'(3));
    applyStimulus(1'b0, '0, '0);
    checkOutput("popValid", 128'(oValid1), 128'(0));

    applyStimulus(1'b1, ADD, 32'h10C);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd1;
    repeat (2) applyStimulus(1'b0, '0, '0);
    checkOutput("stallSig", 128'(oStall1), 128'(1));
    checkOutput("stallValid", 128'(oValid1), 128'(0));
    checkOutput("stallBubble", 128'(oBub1), 128'(2));
    ex_load_valid = 1'b0;
    #1;
    checkOutput("releaseValid", 128'(oValid1), 128'(1));
    applyStimulus(1'b0, '0, '0);

    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd0;
    applyStimulus(1'b1, ADD, 32'h110);
    checkOutput("rd0Stall", 128'(oStall1), 128'(0));
    checkOutput("rd0Valid", 128'(oValid1), 128'(1));
    ex_load_rd = 5'd2;
    #1;
    checkOutput("rs2Stall", 128'(oStall1), 128'(1));
    ex_load_valid = 1'b0;
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, SW, 32'h114);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd8;
    #1;
    checkOutput("unusedRdStall", 128'(oStall1), 128'(0));
    ex_load_valid = 1'b0;
    ex_load_rd    = 5'd0;

    applyStimulus(1'b1, MUL, 32'h120);
    checkOutput("mulMd", 128'(oDec1.md), 128'(1));
    checkOutput("mulOp", 128'(oDec1.mdop), 128'(0));
    checkOutput("mulLr", 128'(oDec1.lr), 128'(1));
    checkOutput("noMIll", 128'(oDec0.ill), 128'(1));
    checkOutput("noMLr", 128'(oDec0.lr), 128'(0));

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, vecs[i], 32'h400 + 32'(i * 4));
    applyStimulus(1'b0, '0, '0);

    out_ready = 1'b0;
    applyStimulus(1'b1, ADD, 32'h200);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, SUB, 32'h204);
      checkOutput("bpReady", 128'(oInReady1), 128'(0));
      checkOutput("bpAluop", 128'(oDec1.aluop), 128'(0));
      checkOutput("bpPc", 128'(oDec1.pc), 128'(32'h200));
    end
    flush = 1'b1;
    applyStimulus(1'b1, SUB, 32'h204);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flushValid", 128'(oValid1), 128'(0));
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0);
    checkOutput("flushIdle", 128'(oValid1), 128'(0));

    applyStimulus(1'b1, ADD, 32'h300);
    ex_load_valid = 1'b1;
    ex_load_rd    = 5'd1;
    applyStimulus(1'b0, '0, '0);
    checkOutput("bubbleBeforeRst", 128'(oBub1), 128'(3));
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0);
    checkOutput("rstStallBubble", 128'(oBub1), 128'(0));
    checkOutput("rstStallValid", 128'(oValid1), 128'(0));
    checkOutput("rstStallReady", 128'(oInReady1), 128'(0));
    rst = 1'b0;
    ex_load_valid = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("afterRstValid", 128'(oValid1), 128'(0));
    checkOutput("afterRstReady", 128'(oInReady1), 128'(1));
    repeat (2) applyStimulus(1'b0, '0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I instruction-decode stage, generalising the combinational control ROM into a pipeline stage. Accepts fetched instructions over a valid/ready handshake, decodes them into the control word plus extracted fields, and holds the result in a one-entry output register. Adds load-use interlock, flush, illegal-instruction detection, optional M-extension decode and a bubble counter. Sits between fetch and execute.

## Interface
- XLEN, 32, datapath width for pc and immediate outputs (immediates sign-extended to XLEN)
- EN_MEXT, 0, 1 = decode RV32M (funct7 = 0000001 on op_reg); 0 = such encodings are illegal
- ILLEGAL_TRAP, 1, 1 = illegal word issues with out_illegal=1 and side effects cleared; 0 = illegal word is dropped (no issue)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1  fetch handshake
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  discard held entry and any same-cycle acceptance
- ex_load_valid  in  1  execute stage holds a load
- ex_load_rd  in  5  destination of that load
- out_valid / out_ready  out / in  1  execute handshake
- out_pc, out_imm  out  XLEN  pc; selected immediate (I/S/B/U/J by opcode)
- out_rs1, out_rs2, out_rd  out  5  register fields (rd forced 0 when load_regfile=0)
- out_opcode  out  7; out_aluop  out  3; out_cmpop  out  3
- out_regfilemux_sel  out  3  (0 alu, 1 br_en, 2 u_imm, 3 load data, 4 pc+4)
- out_alumux1_sel  out  1  (0 rs1, 1 pc); out_alumux2_sel  out  3  (0 i, 1 u, 2 b, 3 s, 4 rs2, 5 j)
- out_cmpmux_sel  out  1  (0 rs2, 1 i_imm)
- out_load_regfile, out_mem_read, out_mem_write  out  1
- out_mem_size  out  2  (0 byte, 1 half, 2 word); out_mem_unsigned  out  1
- out_muldiv  out  1; out_muldiv_op  out  3  (funct3)
- out_illegal  out  1
- stall  out  1  load-use interlock active
- bubble_count  out  16  cycles spent stalled, saturating

## Operation
- aluop: add 000, sll 001, sra 010, sub 011, xor 100, srl 101, or 110, and 111.
- lui: load_regfile, regfilemux 2. auipc: add, alumux1 1, alumux2 1, load_regfile. jal: regfilemux 4, alumux1 1, alumux2 5, add. jalr: regfilemux 4, alumux 0/0, add.
- br: alumux1 1, alumux2 2, add, cmpop=funct3, load_regfile 0.
- load: add, alumux2 0, regfilemux 3, mem_read, load_regfile; size = funct3[1:0], unsigned = funct3[2].
- store: add, alumux2 3, mem_write, size = funct3[1:0], load_regfile 0. Byte enables are computed in execute from the address, not here.
- op_imm/op_reg: slt/sltu select cmpop blt/bltu, regfilemux 1, cmpmux 1 (imm) / 0 (reg); funct7 0100000 selects sub (reg only) or sra; op_reg uses alumux2 4.
- M decode: EN_MEXT=1, op_reg, funct7 0000001 gives muldiv=1, muldiv_op=funct3, load_regfile=1.
- Illegal: unknown opcode; load funct3 011/110/111; store funct3 > 010; branch funct3 010/011; bad funct7 on shifts/op_reg. With ILLEGAL_TRAP=1 the word issues with out_illegal=1 and load_regfile, mem_read, mem_write, muldiv all 0.
- rs1 used by jalr, br, load, store, op_imm, op_reg. rs2 used by br, store, op_reg.
- Interlock: stall = entry held and ex_load_valid and ex_load_rd != 0 and (ex_load_rd == used rs1 or used rs2).

## Timing
- Reset: out_valid 0, all out_* 0, stall 0, bubble_count 0, in_ready 0 while rst high.
- Latency: 1 cycle from acceptance to out_valid (no stall). Throughput: 1/cycle.
- in_ready = !rst && !flush && (!held || (out_valid && out_ready)).
- out_valid = held && !stall. Outputs are stable while out_valid && !out_ready.
- Stall: the entry is held and the consumer sees a bubble. bubble_count increments once per stalled cycle and saturates at 0xFFFF.
- flush: at the next edge held is cleared and no acceptance occurs; flush wins over simultaneous accept, stall and issue.
- Pop and push in the same cycle replace the entry with no bubble.
- rst mid-stall: the entry is discarded and the counter cleared.

## Test plan
- Reset 3 cycles -> out_valid=0, in_ready=0 during rst, in_ready=1 after, bubble_count=0.
- in_instr=0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, aluop=000, alumux2=4, rd=3, rs1=1, rs2=2, load_regfile=1. Then 0x402081B3 -> aluop=011.
- 0x0020A423 (sw x2,8(x1)) -> mem_write=1, mem_size=2, load_regfile=0, rd=0, imm=8, alumux2=3.
- Hold add with ex_load_valid=1, ex_load_rd=1 for 2 cycles -> stall=1, out_valid=0, bubble_count=2. After release, issues next cycle. With ex_load_rd=0 -> no stall.
- 0x022081B3 with EN_MEXT=1 -> muldiv=1, muldiv_op=0. With EN_MEXT=0 -> out_illegal=1, load_regfile=0.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs unchanged, in_ready=0. flush asserted with in_valid=1 -> out_valid=0 next cycle, nothing accepted.
